// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped UART that responds on the core's hardware-register bus.
//   BASE_INDEX+0 TX_DATA (W)   BASE_INDEX+1 STATUS (R, clears error flags)
//   BASE_INDEX+2 RX_DATA (R, pops FIFO)   BASE_INDEX+3 DIVISOR (R/W, min 2)
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   register_index/read/write/write_value   bus request from the core
//   register_read_value     registered read data, zero unless addressed last cycle
//   uart_tx                 serial out (idles high)
//   uart_rx                 serial in, asynchronous to clk
module uart_peripheral #(
  parameter logic [6:0]  BASE_INDEX      = 7'd0,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic [6:0]  rel;
  logic [1:0]  offset;
  logic        hit, wr, rd;

  assign rel    = register_index - BASE_INDEX;
  assign hit    = (register_index >= BASE_INDEX) && (rel < 7'd4);
  assign offset = rel[1:0];
  assign wr     = register_write & hit;
  assign rd     = register_read & ~register_write & hit;

  logic [15:0] divisor;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 divisor <= DEFAULT_DIVISOR;
    else if (wr && offset == 2'd3) divisor <= (register_write_value < 16'd2) ? 16'd2 : register_write_value;
  end

  // ---------------- TX path ----------------
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [3:0]  tx_bit, tx_bit_n;
  logic [8:0]  tx_shift, tx_shift_n;
  logic        tx_out, tx_out_n, tx_load;
  logic        hold_full;
  logic [7:0]  hold_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (tx_load) begin
      hold_full <= 1'b0;
    end else if (wr && offset == 2'd0 && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= register_write_value[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_out   <= tx_out_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_out_n   = tx_out;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: tx_load = hold_full;
      TX_SHIFT: begin
        if (tx_cnt == 16'd0) begin
          if (tx_bit == 4'd9) begin
            // Chain straight into a pending byte so the next start bit follows the stop bit directly.
            if (hold_full) tx_load = 1'b1;
            else           tx_state_n = TX_IDLE;
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            tx_out_n   = tx_shift[0];
            tx_shift_n = {1'b0, tx_shift[8:1]};
            tx_cnt_n   = tx_div - 16'd1;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_state_n = TX_SHIFT;
      tx_shift_n = {1'b1, hold_data};
      tx_out_n   = 1'b0;
      tx_cnt_n   = divisor - 16'd1;
      tx_div_n   = divisor;
      tx_bit_n   = '0;
    end
  end

  assign uart_tx = tx_out;

  // ---------------- RX path ----------------
  logic        rx_meta, rx_s, rx_prev;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_data, rx_data_n;
  logic        rx_push, rx_frame_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_data  <= rx_data_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_div_n     = rx_div;
    rx_bit_n     = rx_bit;
    rx_data_n    = rx_data;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_div_n   = divisor;
          rx_cnt_n   = (divisor >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (rx_cnt == 16'd0) begin
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
          rx_cnt_n   = rx_div - 16'd1;
          rx_bit_n   = '0;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_data_n = {rx_s, rx_data[7:1]};
          rx_cnt_n  = rx_div - 16'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_state_n   = RX_IDLE;
          rx_push      = rx_s;
          rx_frame_err = ~rx_s;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO and flags ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wp, rp;
  logic [2:0] fifo_cnt;
  logic       pop, push_ok, ov_set, clr_flags, overrun, framing;

  assign pop       = rd && offset == 2'd2 && fifo_cnt != 3'd0;
  // A same-cycle pop frees the slot the incoming byte needs.
  assign push_ok   = rx_push && (fifo_cnt != 3'd4 || pop);
  assign ov_set    = rx_push && fifo_cnt == 3'd4 && !pop;
  assign clr_flags = rd && offset == 2'd1;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wp] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      fifo_cnt <= '0;
      overrun  <= 1'b0;
      framing  <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 2'd1;
      if (pop)     rp <= rp + 2'd1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      overrun <= (overrun & ~clr_flags) | ov_set;
      framing <= (framing & ~clr_flags) | rx_frame_err;
    end
  end

  // ---------------- read mux ----------------
  logic [15:0] rd_data;
  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (offset)
        2'd1: rd_data = {8'h00, fifo_cnt, (tx_state == TX_SHIFT), framing, overrun,
                         (fifo_cnt != 3'd0), ~hold_full};
        2'd2: rd_data = (fifo_cnt != 3'd0) ? {8'h00, fifo_mem[rp]} : 16'h0000;
        2'd3: rd_data = divisor;
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) register_read_value <= '0;
    else          register_read_value <= rd_data;
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: directed self-checking bench for uart_peripheral (BASE_INDEX = 8).
module tb_uart_peripheral;

  localparam logic [6:0] BASE = 7'd8;
  localparam logic [6:0] TXD  = BASE;
  localparam logic [6:0] STA  = BASE + 7'd1;
  localparam logic [6:0] RXD  = BASE + 7'd2;
  localparam logic [6:0] DIV  = BASE + 7'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx;

  int errors = 0;
  int checks = 0;

  logic [15:0] v;
  logic        samp [90];

  uart_peripheral #(.BASE_INDEX(BASE), .DEFAULT_DIVISOR(16'd434)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .uart_rx              (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered at a falling edge and return at a falling edge.
  task automatic reg_write(input logic [6:0] idx, input logic [15:0] val);
    register_index = idx;
    register_write_value = val;
    register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic reg_read(input logic [6:0] idx, output logic [15:0] val);
    register_index = idx;
    register_read = 1'b1;
    @(negedge clk);
    register_read = 1'b0;
    val = register_read_value;
  endtask

  // Serial frame at 4 clocks per bit.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int unsigned b = 0; b < 10; b++) begin
      uart_rx = fr[b];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    logic [9:0] fr, f1, f2;
    logic [7:0] bytes [5];
    logic       e;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;

    reset_n = 1'b0;
    register_index = '0;
    register_read = 1'b0;
    register_write = 1'b0;
    register_write_value = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rdval", register_read_value, 16'h0000);
    check("reset_tx", {15'b0, uart_tx}, 16'h0001);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    reg_read(STA, v);  check("status_reset", v, 16'h0001);
    @(negedge clk);    check("rdval_one_cycle", register_read_value, 16'h0000);
    reg_read(DIV, v);  check("div_default", v, 16'd434);
    reg_read(RXD, v);  check("rx_empty", v, 16'h0000);
    reg_read(BASE - 7'd1, v); check("below_window", v, 16'h0000);
    reg_read(BASE + 7'd4, v); check("above_window", v, 16'h0000);

    // Divisor clamp, read+write collision, out-of-window write
    reg_write(DIV, 16'd1); reg_read(DIV, v); check("div_clamp1", v, 16'd2);
    reg_write(DIV, 16'd0); reg_read(DIV, v); check("div_clamp0", v, 16'd2);
    register_index = DIV; register_write_value = 16'd6;
    register_read = 1'b1; register_write = 1'b1;
    @(negedge clk);
    register_read = 1'b0; register_write = 1'b0;
    check("rw_collision_rd", register_read_value, 16'h0000);
    reg_read(DIV, v); check("rw_collision_wr", v, 16'd6);
    reg_write(BASE + 7'd4, 16'd9); reg_read(DIV, v); check("oow_write", v, 16'd6);
    reg_write(DIV, 16'd4); reg_read(DIV, v); check("div_4", v, 16'd4);

    // TX A5 frame, 4 clocks per bit
    reg_write(TXD, 16'h00A5);
    check("tx_idle_before_start", {15'b0, uart_tx}, 16'h0001);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      check("tx_a5", {15'b0, uart_tx}, {15'b0, fr[i / 4]});
    end
    @(negedge clk);
    check("tx_idle_after", {15'b0, uart_tx}, 16'h0001);

    // tx_ready across the load
    reg_write(TXD, 16'h0000);
    reg_read(STA, v); check("status_hold_full", v, 16'h0000);
    reg_read(STA, v); check("status_loaded", v, 16'h0011);
    repeat (45) @(negedge clk);
    reg_read(STA, v); check("status_tx_done", v, 16'h0001);

    // RX 3C
    send_byte(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    reg_read(STA, v); check("status_rx1", v, 16'h0023);
    reg_read(RXD, v); check("rx_3c", v, 16'h003C);
    reg_read(STA, v); check("status_rx_empty", v, 16'h0001);

    // Overrun: five frames, no reads
    for (int unsigned i = 0; i < 5; i++) begin
      send_byte(bytes[i], 1'b1);
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    reg_read(STA, v); check("status_overrun", v, 16'h0087);
    reg_read(STA, v); check("status_ovr_clear", v, 16'h0083);
    for (int unsigned i = 0; i < 4; i++) begin
      reg_read(RXD, v); check("rx_fifo_order", v, {8'h00, bytes[i]});
    end
    reg_read(RXD, v); check("rx_fifo_drained", v, 16'h0000);
    reg_read(STA, v); check("status_drained", v, 16'h0001);

    // Framing error, then a one-clock glitch
    send_byte(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    reg_read(STA, v); check("status_framing", v, 16'h0009);
    reg_read(STA, v); check("status_frm_clear", v, 16'h0001);
    reg_read(RXD, v); check("rx_after_glitch", v, 16'h0000);

    // Back-to-back TX, third write dropped
    reg_write(TXD, 16'h000F);
    fork
      for (int unsigned i = 0; i < 90; i++) begin
        @(negedge clk);
        samp[i] = uart_tx;
      end
      begin
        @(negedge clk);
        reg_write(TXD, 16'h00F0);
        reg_write(TXD, 16'h00AA);
      end
    join
    f1 = {1'b1, 8'h0F, 1'b0};
    f2 = {1'b1, 8'hF0, 1'b0};
    for (int unsigned i = 0; i < 90; i++) begin
      if (i < 40)      e = f1[i / 4];
      else if (i < 80) e = f2[(i - 40) / 4];
      else             e = 1'b1;
      check("tx_b2b", {15'b0, samp[i]}, {15'b0, e});
    end

    // Reset mid-frame
    reg_write(TXD, 16'h0000);
    @(negedge clk);
    check("tx_start_bit", {15'b0, uart_tx}, 16'h0000);
    #2 reset_n = 1'b0;
    #1 check("tx_async_reset", {15'b0, uart_tx}, 16'h0001);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reg_read(DIV, v); check("div_after_reset", v, 16'd434);
    reg_read(STA, v); check("status_after_reset", v, 16'h0001);
    check("tx_after_reset", {15'b0, uart_tx}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
